// File: rtl/trigger_staged.sv
// Sequential multi-stage trigger between the sampler stream and capture control.
// Each stage matches value/mask plus per-bit edges and must occur `count` times before advancing.
module trigger_staged #(
  parameter int SAMPLE_WIDTH = 8,
  parameter int STAGES       = 4,
  parameter int COUNT_WIDTH  = 16,
  localparam int STAGE_W     = (STAGES > 1) ? $clog2(STAGES) : 1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    arm,
  input  logic                    disarm,
  input  logic                    valid,
  input  logic [SAMPLE_WIDTH-1:0] dataIn,
  input  logic                    cfg_we,
  input  logic [STAGE_W-1:0]      cfg_stage,
  input  logic [2:0]              cfg_field,
  input  logic [31:0]             cfg_data,
  output logic                    cfg_err,
  output logic                    armed,
  output logic [STAGE_W-1:0]      stage,
  output logic                    run,
  output logic                    trig_pulse
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_TRIG  = 2'd2
  } state_t;

  localparam logic [2:0] FLD_VALUE = 3'd0;
  localparam logic [2:0] FLD_MASK  = 3'd1;
  localparam logic [2:0] FLD_RISE  = 3'd2;
  localparam logic [2:0] FLD_FALL  = 3'd3;
  localparam logic [2:0] FLD_COUNT = 3'd4;
  localparam logic [2:0] FLD_LAST  = 3'd5;

  logic [SAMPLE_WIDTH-1:0] value_r [STAGES];
  logic [SAMPLE_WIDTH-1:0] mask_r  [STAGES];
  logic [SAMPLE_WIDTH-1:0] rise_r  [STAGES];
  logic [SAMPLE_WIDTH-1:0] fall_r  [STAGES];
  logic [COUNT_WIDTH-1:0]  count_r [STAGES];
  logic [STAGE_W-1:0]      last_stage_r;

  state_t                  state_r;
  state_t                  state_next_s;
  logic [STAGE_W-1:0]      stage_r;
  logic [COUNT_WIDTH-1:0]  counter_r;
  logic [SAMPLE_WIDTH-1:0] prev_r;
  logic                    prev_valid_r;

  logic                    armed_r;
  logic                    run_r;
  logic                    trig_pulse_r;
  logic                    cfg_err_r;
  logic                    armed_s;
  logic                    run_s;
  logic                    trig_pulse_s;

  logic [SAMPLE_WIDTH-1:0] cur_value_s;
  logic [SAMPLE_WIDTH-1:0] cur_mask_s;
  logic [SAMPLE_WIDTH-1:0] cur_rise_s;
  logic [SAMPLE_WIDTH-1:0] cur_fall_s;
  logic [COUNT_WIDTH-1:0]  cur_count_s;
  logic [COUNT_WIDTH-1:0]  eff_count_s;
  logic [COUNT_WIDTH:0]    count_next_s;
  logic                    level_ok_s;
  logic                    rise_ok_s;
  logic                    fall_ok_s;
  logic                    match_s;
  logic                    complete_s;
  logic                    eval_s;
  logic                    last_s;
  logic                    cfg_ok_s;

  // Match evaluation against the active stage's configuration
  always_comb begin
    cur_value_s  = value_r[stage_r];
    cur_mask_s   = mask_r[stage_r];
    cur_rise_s   = rise_r[stage_r];
    cur_fall_s   = fall_r[stage_r];
    cur_count_s  = count_r[stage_r];
    level_ok_s   = (((dataIn ^ cur_value_s) & cur_mask_s) == {SAMPLE_WIDTH{1'b0}});
    rise_ok_s    = ((cur_rise_s & ~(~prev_r & dataIn)) == {SAMPLE_WIDTH{1'b0}});
    fall_ok_s    = ((cur_fall_s & ~(prev_r & ~dataIn)) == {SAMPLE_WIDTH{1'b0}});
    // Edge terms are meaningless until a previous sample exists in this run
    if (!prev_valid_r && ((cur_rise_s | cur_fall_s) != {SAMPLE_WIDTH{1'b0}})) begin
      match_s = 1'b0;
    end else begin
      match_s = level_ok_s & rise_ok_s & fall_ok_s;
    end
    if (cur_count_s == {COUNT_WIDTH{1'b0}}) begin
      eff_count_s = COUNT_WIDTH'(1);
    end else begin
      eff_count_s = cur_count_s;
    end
    count_next_s = {1'b0, counter_r} + (COUNT_WIDTH + 1)'(1);
    complete_s   = match_s && (count_next_s >= {1'b0, eff_count_s});
    eval_s       = (state_r == ST_ARMED) && valid && !arm && !disarm;
    last_s       = (stage_r == last_stage_r);
  end

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic; disarm has priority over arm
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (disarm) begin
          state_next_s = ST_IDLE;
        end else if (arm) begin
          state_next_s = ST_ARMED;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_ARMED: begin
        if (disarm) begin
          state_next_s = ST_IDLE;
        end else if (arm) begin
          state_next_s = ST_ARMED;
        end else if (eval_s && complete_s && last_s) begin
          state_next_s = ST_TRIG;
        end else begin
          state_next_s = ST_ARMED;
        end
      end
      ST_TRIG: begin
        if (disarm) begin
          state_next_s = ST_IDLE;
        end else if (arm) begin
          state_next_s = ST_ARMED;
        end else begin
          state_next_s = ST_TRIG;
        end
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // Output decode from the upcoming state so the flags register in step with it
  always_comb begin
    armed_s      = (state_next_s == ST_ARMED);
    run_s        = (state_next_s == ST_TRIG);
    trig_pulse_s = (state_r == ST_ARMED) && (state_next_s == ST_TRIG);
  end

  // Output registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      armed_r      <= 1'b0;
      run_r        <= 1'b0;
      trig_pulse_r <= 1'b0;
      cfg_err_r    <= 1'b0;
    end else begin
      armed_r      <= armed_s;
      run_r        <= run_s;
      trig_pulse_r <= trig_pulse_s;
      cfg_err_r    <= cfg_we && !cfg_ok_s;
    end
  end

  // Sequence datapath: stage index, occurrence counter and edge history
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stage_r      <= {STAGE_W{1'b0}};
      counter_r    <= {COUNT_WIDTH{1'b0}};
      prev_r       <= {SAMPLE_WIDTH{1'b0}};
      prev_valid_r <= 1'b0;
    end else if (arm || disarm) begin
      stage_r      <= {STAGE_W{1'b0}};
      counter_r    <= {COUNT_WIDTH{1'b0}};
      prev_valid_r <= 1'b0;
    end else if (eval_s) begin
      prev_r       <= dataIn;
      prev_valid_r <= 1'b1;
      if (complete_s) begin
        counter_r <= {COUNT_WIDTH{1'b0}};
        if (!last_s) begin
          stage_r <= stage_r + STAGE_W'(1);
        end
      end else if (match_s) begin
        if (counter_r != {COUNT_WIDTH{1'b1}}) begin
          counter_r <= counter_r + COUNT_WIDTH'(1);
        end
      end
    end
  end

  // Config write acceptance: never while ARMED, and only for in-range targets
  always_comb begin
    cfg_ok_s = 1'b0;
    if (cfg_we && (state_r != ST_ARMED)) begin
      case (cfg_field)
        FLD_VALUE, FLD_MASK, FLD_RISE, FLD_FALL, FLD_COUNT:
          cfg_ok_s = (int'(cfg_stage) < STAGES);
        FLD_LAST:
          cfg_ok_s = (cfg_data < 32'(STAGES));
        default:
          cfg_ok_s = 1'b0;
      endcase
    end else begin
      cfg_ok_s = 1'b0;
    end
  end

  // Configuration registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < STAGES; i++) begin
        value_r[i] <= {SAMPLE_WIDTH{1'b0}};
        mask_r[i]  <= {SAMPLE_WIDTH{1'b0}};
        rise_r[i]  <= {SAMPLE_WIDTH{1'b0}};
        fall_r[i]  <= {SAMPLE_WIDTH{1'b0}};
        count_r[i] <= COUNT_WIDTH'(1);
      end
      last_stage_r <= STAGE_W'(STAGES - 1);
    end else if (cfg_ok_s) begin
      if (cfg_field == FLD_LAST) begin
        last_stage_r <= cfg_data[STAGE_W-1:0];
      end
      for (int i = 0; i < STAGES; i++) begin
        if (int'(cfg_stage) == i) begin
          case (cfg_field)
            FLD_VALUE: value_r[i] <= cfg_data[SAMPLE_WIDTH-1:0];
            FLD_MASK:  mask_r[i]  <= cfg_data[SAMPLE_WIDTH-1:0];
            FLD_RISE:  rise_r[i]  <= cfg_data[SAMPLE_WIDTH-1:0];
            FLD_FALL:  fall_r[i]  <= cfg_data[SAMPLE_WIDTH-1:0];
            FLD_COUNT: count_r[i] <= cfg_data[COUNT_WIDTH-1:0];
            default:   value_r[i] <= value_r[i];
          endcase
        end
      end
    end
  end

  assign cfg_err    = cfg_err_r;
  assign armed      = armed_r;
  assign stage      = stage_r;
  assign run        = run_r;
  assign trig_pulse = trig_pulse_r;

endmodule

// File: tb/tb_trigger_staged.sv
// Bench for trigger_staged: directed steps plus random traffic, each cycle compared
// against a per-bit behavioural model of the trigger sequence.
module tb_trigger_staged;
  localparam int SW  = 8;
  localparam int NS  = 5;
  localparam int CW  = 16;
  localparam int STW = 3;

  logic           clock = 1'b0;
  logic           reset = 1'b1;
  logic           arm = 1'b0;
  logic           disarm = 1'b0;
  logic           valid = 1'b0;
  logic [SW-1:0]  dataIn = 8'h00;
  logic           cfg_we = 1'b0;
  logic [STW-1:0] cfg_stage = 3'd0;
  logic [2:0]     cfg_field = 3'd0;
  logic [31:0]    cfg_data = 32'd0;
  logic           cfg_err;
  logic           armed;
  logic [STW-1:0] stage;
  logic           run;
  logic           trig_pulse;

  int errors = 0;
  int checks = 0;

  // reference model: mode 0 idle, 1 armed, 2 triggered
  int         m_mode;
  int         m_stage;
  int         m_hits;
  logic [7:0] m_prev;
  bit         m_have_prev;
  logic [7:0] c_val [NS];
  logic [7:0] c_mask[NS];
  logic [7:0] c_rise[NS];
  logic [7:0] c_fall[NS];
  int         c_cnt [NS];
  int         c_last;
  bit         e_pulse;
  bit         e_err;

  trigger_staged #(.SAMPLE_WIDTH(SW), .STAGES(NS), .COUNT_WIDTH(CW)) dut (
    .clock(clock), .reset(reset), .arm(arm), .disarm(disarm), .valid(valid),
    .dataIn(dataIn), .cfg_we(cfg_we), .cfg_stage(cfg_stage), .cfg_field(cfg_field),
    .cfg_data(cfg_data), .cfg_err(cfg_err), .armed(armed), .stage(stage),
    .run(run), .trig_pulse(trig_pulse)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NS; i++) begin
      c_val[i] = 8'h00; c_mask[i] = 8'h00; c_rise[i] = 8'h00; c_fall[i] = 8'h00;
      c_cnt[i] = 1;
    end
    c_last = NS - 1;
    m_mode = 0; m_stage = 0; m_hits = 0; m_prev = 8'h00; m_have_prev = 1'b0;
    e_pulse = 1'b0; e_err = 1'b0;
  endtask

  task automatic model(input logic a, input logic d, input logic v, input logic [7:0] x,
                       input logic we, input int st, input int fld, input logic [31:0] dat);
    bit ok;
    int need;
    e_pulse = 1'b0;
    e_err   = 1'b0;
    if (we) begin
      if (m_mode == 1 || fld > 5 || (fld < 5 && st >= NS) || (fld == 5 && dat >= 32'(NS)))
        e_err = 1'b1;
      else begin
        case (fld)
          0: c_val[st]  = dat[7:0];
          1: c_mask[st] = dat[7:0];
          2: c_rise[st] = dat[7:0];
          3: c_fall[st] = dat[7:0];
          4: c_cnt[st]  = int'(dat[15:0]);
          default: c_last = int'(dat);
        endcase
      end
    end
    if (d) begin
      m_mode = 0; m_stage = 0; m_hits = 0; m_have_prev = 1'b0;
    end else if (a) begin
      m_mode = 1; m_stage = 0; m_hits = 0; m_have_prev = 1'b0;
    end else if (m_mode == 1 && v) begin
      ok = 1'b1;
      for (int b = 0; b < SW; b++) begin
        if (c_mask[m_stage][b] && (x[b] != c_val[m_stage][b])) ok = 1'b0;
        if (c_rise[m_stage][b] && !(m_have_prev && !m_prev[b] && x[b])) ok = 1'b0;
        if (c_fall[m_stage][b] && !(m_have_prev && m_prev[b] && !x[b])) ok = 1'b0;
      end
      if (ok) begin
        need = (c_cnt[m_stage] == 0) ? 1 : c_cnt[m_stage];
        m_hits++;
        if (m_hits >= need) begin
          m_hits = 0;
          if (m_stage == c_last) begin
            m_mode  = 2;
            e_pulse = 1'b1;
          end else begin
            m_stage++;
          end
        end
      end
      m_prev = x;
      m_have_prev = 1'b1;
    end
  endtask

  task automatic check_all();
    chk("armed", {31'd0, armed}, (m_mode == 1) ? 32'd1 : 32'd0);
    chk("run", {31'd0, run}, (m_mode == 2) ? 32'd1 : 32'd0);
    chk("trig_pulse", {31'd0, trig_pulse}, {31'd0, e_pulse});
    chk("cfg_err", {31'd0, cfg_err}, {31'd0, e_err});
    if (m_mode != 0) chk("stage", {29'd0, stage}, 32'(m_stage));
  endtask

  task automatic step(input logic a, input logic d, input logic v, input logic [7:0] x,
                      input logic we = 1'b0, input int st = 0, input int fld = 0,
                      input logic [31:0] dat = 32'd0);
    @(negedge clock);
    arm = a; disarm = d; valid = v; dataIn = x;
    cfg_we = we; cfg_stage = st[2:0]; cfg_field = fld[2:0]; cfg_data = dat;
    model(a, d, v, x, we, st, fld, dat);
    @(posedge clock);
    #1;
    check_all();
    arm = 1'b0; disarm = 1'b0; valid = 1'b0; cfg_we = 1'b0;
  endtask

  task automatic sample(input logic [7:0] x);
    step(1'b0, 1'b0, 1'b1, x);
  endtask

  task automatic wcfg(input int st, input int fld, input logic [31:0] dat);
    step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, st, fld, dat);
  endtask

  initial begin
    logic        ra, rd, rv, rwe;
    logic [7:0]  rx;
    int          rst_i, rfld;
    logic [31:0] rdat;

    model_reset();
    #1;
    chk("reset_run", {31'd0, run}, 32'd0);
    chk("reset_armed", {31'd0, armed}, 32'd0);
    chk("reset_stage", {29'd0, stage}, 32'd0);
    @(negedge clock);
    reset = 1'b0;

    // single stage level match
    wcfg(0, 0, 32'h0000_00A5);
    wcfg(0, 1, 32'h0000_00FF);
    wcfg(0, 4, 32'd1);
    wcfg(0, 5, 32'd0);
    step(1'b1, 1'b0, 1'b0, 8'h00);
    sample(8'h00);
    chk("tp1_no_run", {31'd0, run}, 32'd0);
    sample(8'hA5);
    chk("tp1_run", {31'd0, run}, 32'd1);
    chk("tp1_pulse", {31'd0, trig_pulse}, 32'd1);
    sample(8'hA5);
    chk("tp1_pulse_len", {31'd0, trig_pulse}, 32'd0);

    // rising edge, first sample after arm cannot match
    wcfg(0, 1, 32'd0);
    wcfg(0, 2, 32'h0000_0001);
    step(1'b1, 1'b0, 1'b0, 8'h00);
    sample(8'h01);
    chk("edge_first", {31'd0, run}, 32'd0);
    sample(8'h00);
    sample(8'h01);
    chk("edge_run", {31'd0, run}, 32'd1);

    // two stages with occurrence count and falling edge
    wcfg(0, 2, 32'd0);
    wcfg(0, 1, 32'h0000_00FF);
    wcfg(0, 0, 32'h0000_0010);
    wcfg(0, 4, 32'd3);
    wcfg(1, 3, 32'h0000_0080);
    wcfg(0, 5, 32'd1);
    step(1'b1, 1'b0, 1'b0, 8'h00);
    sample(8'h10); sample(8'h00); sample(8'h10);
    chk("two_stage_s0", {29'd0, stage}, 32'd0);
    sample(8'h10);
    chk("two_stage_s1", {29'd0, stage}, 32'd1);
    sample(8'h80);
    sample(8'h00);
    chk("two_stage_run", {31'd0, run}, 32'd1);

    // count 0 behaves as 1, and valid gaps never count
    wcfg(0, 5, 32'd0);
    wcfg(0, 4, 32'd0);
    step(1'b1, 1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b0, 1'b0, 8'h10);
    step(1'b0, 1'b0, 1'b0, 8'h10);
    chk("gap_no_run", {31'd0, run}, 32'd0);
    sample(8'h10);
    chk("count0_run", {31'd0, run}, 32'd1);
    wcfg(0, 4, 32'd2);
    step(1'b1, 1'b0, 1'b0, 8'h00);
    sample(8'h10);
    step(1'b0, 1'b0, 1'b0, 8'h10);
    step(1'b0, 1'b0, 1'b0, 8'h10);
    chk("count2_wait", {31'd0, run}, 32'd0);
    sample(8'h10);
    chk("count2_run", {31'd0, run}, 32'd1);

    // config rejection and acceptance
    step(1'b1, 1'b0, 1'b0, 8'h00);
    wcfg(0, 0, 32'h0000_0055);
    chk("err_armed", {31'd0, cfg_err}, 32'd1);
    sample(8'h10);
    sample(8'h10);
    chk("cfg_unchanged_run", {31'd0, run}, 32'd1);
    wcfg(5, 0, 32'd0);
    chk("err_stage", {31'd0, cfg_err}, 32'd1);
    wcfg(0, 6, 32'd0);
    wcfg(0, 5, 32'd5);
    chk("err_last", {31'd0, cfg_err}, 32'd1);
    wcfg(4, 0, 32'h0000_003C);
    chk("accept_trig", {31'd0, cfg_err}, 32'd0);

    // arm mid-sequence clears stage and counter
    wcfg(0, 1, 32'd0);
    wcfg(0, 4, 32'd1);
    wcfg(1, 3, 32'd0);
    wcfg(2, 4, 32'd2);
    wcfg(0, 5, 32'd2);
    step(1'b1, 1'b0, 1'b0, 8'h00);
    sample(8'h11); sample(8'h22); sample(8'h33);
    chk("mid_stage2", {29'd0, stage}, 32'd2);
    step(1'b1, 1'b0, 1'b0, 8'h00);
    chk("rearm_stage0", {29'd0, stage}, 32'd0);
    sample(8'h44); sample(8'h55); sample(8'h66);
    chk("rearm_counter0", {31'd0, run}, 32'd0);
    sample(8'h77);
    chk("rearm_run", {31'd0, run}, 32'd1);

    // arm and disarm together: disarm wins
    step(1'b1, 1'b1, 1'b0, 8'h00);
    chk("arm_disarm", {31'd0, armed}, 32'd0);
    step(1'b1, 1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b1, 1'b0, 8'h00);

    // random traffic against the model
    for (int i = 0; i < 800; i++) begin
      ra    = ($urandom_range(0, 99) < 6);
      rd    = ($urandom_range(0, 99) < 2);
      rv    = ($urandom_range(0, 99) < 70);
      rx    = 8'($urandom_range(0, 255));
      rwe   = ($urandom_range(0, 99) < 10);
      rst_i = $urandom_range(0, 7);
      rfld  = $urandom_range(0, 6);
      case (rfld)
        0:       rdat = 32'($urandom_range(0, 255));
        1:       rdat = 32'($urandom_range(0, 3));
        2, 3:    rdat = ($urandom_range(0, 4) == 0) ? 32'($urandom_range(0, 3)) : 32'd0;
        4:       rdat = 32'($urandom_range(0, 3));
        5:       rdat = 32'($urandom_range(0, 6));
        default: rdat = $urandom;
      endcase
      step(ra, rd, rv, rx, rwe, rst_i, rfld, rdat);
    end

    // asynchronous reset while triggered
    step(1'b0, 1'b1, 1'b0, 8'h00);
    wcfg(0, 5, 32'd0);
    wcfg(0, 1, 32'd0);
    wcfg(0, 2, 32'd0);
    wcfg(0, 3, 32'd0);
    wcfg(0, 4, 32'd1);
    step(1'b1, 1'b0, 1'b0, 8'h00);
    sample(8'h5A);
    chk("pre_reset_run", {31'd0, run}, 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("async_run", {31'd0, run}, 32'd0);
    chk("async_armed", {31'd0, armed}, 32'd0);
    chk("async_stage", {29'd0, stage}, 32'd0);
    model_reset();
    @(negedge clock);
    reset = 1'b0;

    // defaults: every stage matches anything once, last stage is NS-1
    step(1'b1, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < NS - 1; i++) sample(8'($urandom_range(0, 255)));
    chk("default_wait", {31'd0, run}, 32'd0);
    sample(8'h00);
    chk("default_count1", {31'd0, run}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/trigger_staged.md
Name: trigger_staged

Overview:
- Parametrised successor to the basic edge/level trigger: a sequential trigger of up to STAGES stages.
- Each stage matches value/mask plus per-bit rising/falling edges, with a per-stage occurrence count.
- Sits between the sampler (valid/data stream) and capture control; asserts run when the last enabled stage completes.
- Per-stage configuration is loaded through a register write port driven by the UART command decoder.

Parameters:
- SAMPLE_WIDTH, 8, sample bus width (1..32).
- STAGES, 4, number of trigger stages (1..8).
- COUNT_WIDTH, 16, occurrence counter width per stage.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- arm  in  1  single-cycle pulse: start/restart sequence at stage 0.
- disarm  in  1  single-cycle pulse: return to IDLE.
- valid  in  1  sample qualifier from sampler.
- dataIn  in  SAMPLE_WIDTH  sample from sampler.
- cfg_we  in  1  config write strobe.
- cfg_stage  in  $clog2(STAGES) (min 1)  stage select.
- cfg_field  in  3  0=value, 1=mask, 2=rise, 3=fall, 4=count, 5=last_stage (global; cfg_stage ignored).
- cfg_data  in  32  write data, LSB-aligned, truncated to field width.
- cfg_err  out  1  one-cycle pulse: write rejected.
- armed  out  1  high in ARMED.
- stage  out  $clog2(STAGES) (min 1)  current stage index.
- run  out  1  high in TRIGGERED.
- trig_pulse  out  1  one-cycle pulse on entry to TRIGGERED.

Behaviour:
- Reset: state IDLE. All config registers 0, except count=1 and last_stage=STAGES-1. prev sample, prev_valid flag and occurrence counter cleared. All outputs 0.
- States:
  - IDLE: arm -> ARMED.
  - ARMED: stage completes and it is the last stage -> TRIGGERED; arm -> ARMED (restart); disarm -> IDLE.
  - TRIGGERED: arm -> ARMED; disarm -> IDLE.
- Any arm: stage=0, counter=0, prev_valid=0. If arm and disarm are high in the same cycle, disarm wins.
- Match, evaluated only on a valid cycle in ARMED, using stage S registers:
  - level_ok = ((dataIn ^ value) & mask) == 0.
  - rise_ok = (rise & ~(~prev & dataIn)) == 0.
  - fall_ok = (fall & ~(prev & ~dataIn)) == 0.
  - match = level_ok & rise_ok & fall_ok.
  - While prev_valid=0, any nonzero rise/fall forces match=0.
- Every valid cycle in ARMED: prev <= dataIn, prev_valid <= 1.
- Occurrences (cumulative, non-contiguous):
  - On match with counter+1 >= count, the stage completes. A count of 0 is treated as 1.
  - On completion: counter <= 0. If S == last_stage -> TRIGGERED; otherwise stage <= S+1.
  - On match without completion: counter <= counter+1. Non-match: no change.
- The counter saturates at all-ones; it never wraps.
- Latency: a completing valid sample in cycle t gives run=1 and trig_pulse=1 in cycle t+1. Stage advance is likewise visible at t+1. The next stage first evaluates the following valid sample (one sample per stage step).
- A valid=0 cycle leaves state, counter and prev untouched.
- Config writes:
  - Accepted only in IDLE or TRIGGERED; in ARMED they are ignored and cfg_err pulses at t+1.
  - cfg_stage >= STAGES, field > 5, or last_stage data >= STAGES: write ignored, cfg_err pulses.
- run holds until arm, disarm or reset. stage holds its final value in TRIGGERED.
- An asynchronous reset mid-sequence returns everything to reset values immediately.

Test Plan:
- Single stage, last_stage=0, value=0xA5, mask=0xFF, count=1. arm, then valid samples 0x00, 0xA5 -> run=1 and trig_pulse=1 one cycle after 0xA5; trig_pulse lasts exactly 1 cycle.
- Edge: rise=0x01, mask=0. First valid sample after arm is 0x01 -> no match. Then 0x00, 0x01 -> run rises after the second 0x01.
- Two stages, last_stage=1: stage0 value 0x10 count=3; stage1 fall=0x80. Feed 0x10, 0x00, 0x10, 0x10 -> stage=1 after the 4th sample. Then 0x80, 0x00 -> run=1.
- Occurrence counting: count=0 behaves as count=1. Valid gaps (valid=0 with matching data) do not count.
- cfg_we while ARMED -> cfg_err pulse, config unchanged. cfg_stage=STAGES -> cfg_err. A write in TRIGGERED is accepted.
- arm mid-sequence at stage 2 -> stage=0 and counter=0. arm+disarm in the same cycle -> IDLE. reset asserted while TRIGGERED -> run=0 asynchronously, count fields read back as 1.
